nn_frame_feeder: RTL and testbench

Front-end producer for the 48->16->3 uint8 classifier. Receives a serial uint8 byte stream over a valid/ready handshake and assembles one 48-byte frame into a flat pixel bus. It then issues a single-cycle start pulse to the classifier and holds the bus stable until the classifier's done/class result returns. The result, or a timeout indication, is returned to the stream source on a valid/ready result handshake.

---
 rtl/nn_frame_feeder_if.sv | 39 +++
 rtl/nn_frame_feeder.sv | 130 +++++++++++++
 tb/tb_nn_frame_feeder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_frame_feeder_if.sv
// nn_frame_feeder_if
// Groups the signals of the frame feeder's three handshakes into one bundle:
// the byte stream in, the classifier start/done exchange and the result
// stream back to the source.
//   slave  : the feeder side (drives s_ready, nn_valid, pixel_bus, r_*,
//            frame_err, frames_done)
//   master : the environment side (drives s_valid/s_data/s_last,
//            nn_done/nn_class, r_ready)
interface nn_frame_feeder_if #(
    parameter int NUM_BYTES = 48,
    parameter int CNT_W     = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic [7:0]               s_data;
    logic                     s_last;
    logic                     nn_valid;
    logic [8*NUM_BYTES-1:0]   pixel_bus;
    logic                     nn_done;
    logic [1:0]               nn_class;
    logic                     r_valid;
    logic                     r_ready;
    logic [1:0]               r_class;
    logic                     r_timeout;
    logic                     frame_err;
    logic [CNT_W-1:0]         frames_done;

    modport slave (
        input  s_valid, s_data, s_last, nn_done, nn_class, r_ready,
        output s_ready, nn_valid, pixel_bus, r_valid, r_class, r_timeout,
               frame_err, frames_done
    );

    modport master (
        output s_valid, s_data, s_last, nn_done, nn_class, r_ready,
        input  s_ready, nn_valid, pixel_bus, r_valid, r_class, r_timeout,
               frame_err, frames_done
    );
endinterface

// File: rtl/nn_frame_feeder.sv
// nn_frame_feeder
// Collects a NUM_BYTES uint8 frame from a valid/ready byte stream onto a flat
// pixel bus, starts the classifier with a one-cycle nn_valid pulse, holds the
// bus until nn_done (or a timeout) and hands the class back on a valid/ready
// result handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : nn_frame_feeder_if.slave (byte stream, classifier, result,
//           frame_err pulse, frames_done counter)
module nn_frame_feeder #(
    parameter int NUM_BYTES      = 48,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    nn_frame_feeder_if.slave   bus
);

    localparam int BC_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TC_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [BC_W-1:0] LAST_SLOT = BC_W'(NUM_BYTES - 1);
    // The counter is compared before it increments, so hitting TIMEOUT_CYCLES-2
    // here means it would reach TIMEOUT_CYCLES-1 on this cycle.
    localparam logic [TC_W-1:0] TO_LAST   = TC_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [BC_W-1:0]        byte_cnt;
    logic [TC_W-1:0]        tcnt;
    logic                   drop;
    logic [8*NUM_BYTES-1:0] pix;
    logic [1:0]             r_class_q;
    logic                   r_timeout_q;
    logic                   frame_err_q;
    logic [CNT_W-1:0]       done_cnt;

    logic xfer;
    logic at_last;
    logic wait_timeout;

    always_comb begin
        xfer         = bus.s_valid && (state == FILL);
        at_last      = (byte_cnt == LAST_SLOT);
        wait_timeout = (tcnt == TO_LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (xfer && !drop && bus.s_last && at_last) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (bus.nn_done || wait_timeout) state_nxt = REPORT;
            REPORT:  if (bus.r_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            tcnt        <= '0;
            drop        <= 1'b0;
            pix         <= '0;
            r_class_q   <= '0;
            r_timeout_q <= 1'b0;
            frame_err_q <= 1'b0;
            done_cnt    <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                FILL: begin
                    if (xfer) begin
                        if (drop) begin
                            // Discarding the tail of an over-long frame.
                            if (bus.s_last) drop <= 1'b0;
                        end else begin
                            pix[8*int'(byte_cnt) +: 8] <= bus.s_data;
                            if (bus.s_last) begin
                                byte_cnt <= '0;
                                if (!at_last) frame_err_q <= 1'b1;
                            end else if (at_last) begin
                                byte_cnt    <= '0;
                                frame_err_q <= 1'b1;
                                drop        <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                end
                LAUNCH: tcnt <= '0;
                WAIT: begin
                    if (bus.nn_done) begin
                        r_class_q   <= bus.nn_class;
                        r_timeout_q <= 1'b0;
                    end else if (wait_timeout) begin
                        r_class_q   <= 2'b11;
                        r_timeout_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                REPORT: if (bus.r_ready) done_cnt <= done_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.s_ready     = (state == FILL);
    assign bus.nn_valid    = (state == LAUNCH);
    assign bus.r_valid     = (state == REPORT);
    assign bus.pixel_bus   = pix;
    assign bus.r_class     = r_class_q;
    assign bus.r_timeout   = r_timeout_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frames_done = done_cnt;

endmodule

// File: tb/tb_nn_frame_feeder.sv
module tb_nn_frame_feeder;

    localparam int NB = 48;
    localparam int TO = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nn_frame_feeder_if #(.NUM_BYTES(NB), .CNT_W(CW)) bus ();

    nn_frame_feeder #(
        .NUM_BYTES      (NB),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        int         nbytes;
        int         last_idx;
        int         delay;       // nn_done cycles after nn_valid; 0 = never
        logic [1:0] cls;
        int         exp_err;
        int         exp_launch;
        logic       exp_to;
        logic [1:0] exp_cls;
    } vec_t;

    typedef struct {
        logic [1:0] cls;
        logic       to;
    } res_t;

    res_t            sb[$];
    int              total = 0;
    int              bad   = 0;
    int              nv_cnt = 0;
    int              fe_cnt = 0;
    int              exp_frames = 0;
    logic [8*NB-1:0] exp_bus = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic check_bus(input string nm, input logic [8*NB-1:0] act, input logic [8*NB-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got byte0=%0h byte47=%0h expected byte0=%0h byte47=%0h",
                     nm, act[7:0], act[8*NB-1 -: 8], req[7:0], req[8*NB-1 -: 8]);
        end
    endtask

    // Per-cycle observation at the falling edge.
    task automatic sample();
        res_t e;
        if (!rst_n) begin
            exp_frames = 0;
            return;
        end
        if (bus.nn_valid)  nv_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (!bus.s_ready) check_bus("pixel_hold", bus.pixel_bus, exp_bus);
        if (bus.r_valid && bus.r_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got class %0d timeout %0d, required none",
                         bus.r_class, bus.r_timeout);
            end else begin
                e = sb.pop_front();
                check("r_class", 64'(bus.r_class), 64'(e.cls));
                check("r_timeout", 64'(bus.r_timeout), 64'(e.to));
            end
            exp_frames++;
        end
    endtask

    task automatic tick(output logic rdy);
        @(negedge clk);
        sample();
        rdy = bus.s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        logic r;
        repeat (n) tick(r);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        logic rdy;
        int   guard;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        tick(rdy);
        while (!rdy && guard < 100) begin
            guard++;
            tick(rdy);
        end
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL s_ready_wait: got s_ready=0 for 100 cycles, required 1");
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input string nm, input int nbytes, input int last_idx,
                              input int seed, input int launch);
        logic [7:0] d;
        for (int i = 0; i < nbytes; i++) begin
            d = 8'((i + 7 * seed) & 255);
            if (launch != 0 && i < NB) exp_bus[8*i +: 8] = d;
            push_byte(d, i == last_idx);
            if (nbytes > NB && i == NB - 1)
                check({nm, ":err_at_last_slot"}, 64'(bus.frame_err), 1);
        end
    endtask

    task automatic apply(input vec_t v, input int seed);
        int   nv0;
        int   fe0;
        res_t r;
        nv0 = nv_cnt;
        fe0 = fe_cnt;
        if (v.exp_launch != 0) begin
            r.cls = v.exp_cls;
            r.to  = v.exp_to;
            sb.push_back(r);
        end
        send_frame(v.name, v.nbytes, v.last_idx, seed, v.exp_launch);
        if (v.nbytes < NB) check({v.name, ":short_err"}, 64'(bus.frame_err), 1);
        if (v.exp_launch != 0) begin
            check({v.name, ":launch_latency"}, 64'(bus.nn_valid), 1);
            if (!v.exp_to) begin
                step(v.delay);
                bus.nn_done  = 1'b1;
                bus.nn_class = v.cls;
                step(1);
                bus.nn_done  = 1'b0;
                bus.nn_class = 2'b00;
                check({v.name, ":result_latency"}, 64'(bus.r_valid), 1);
            end else begin
                step(TO - 1);
                check({v.name, ":no_early_timeout"}, 64'(bus.r_valid), 0);
                step(1);
                check({v.name, ":timeout_latency"}, 64'(bus.r_valid), 1);
            end
            step(1);
            check({v.name, ":ready_after_result"}, 64'(bus.s_ready), 1);
            if (v.exp_to) begin
                bus.nn_done  = 1'b1;
                bus.nn_class = 2'b01;
                step(1);
                bus.nn_done  = 1'b0;
                step(1);
                check({v.name, ":late_done_ignored"}, 64'(bus.r_valid), 0);
            end
        end else begin
            step(3);
        end
        check({v.name, ":launch_count"}, 64'(nv_cnt - nv0), 64'(v.exp_launch));
        check({v.name, ":err_count"}, 64'(fe_cnt - fe0), 64'(v.exp_err));
        check({v.name, ":frames_done"}, 64'(bus.frames_done), 64'(exp_frames));
        check({v.name, ":sb_drained"}, 64'(sb.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   hold_bad;
        res_t r;

        vecs[0] = '{"normal",     48, 47, 12,     2'b01, 0, 1, 1'b0, 2'b01};
        vecs[1] = '{"short",      11, 10, 0,      2'b00, 1, 0, 1'b0, 2'b00};
        vecs[2] = '{"after_short",48, 47, 3,      2'b10, 0, 1, 1'b0, 2'b10};
        vecs[3] = '{"long",       60, 59, 0,      2'b00, 1, 0, 1'b0, 2'b00};
        vecs[4] = '{"after_long", 48, 47, 1,      2'b11, 0, 1, 1'b0, 2'b11};
        vecs[5] = '{"done_at_to", 48, 47, TO - 1, 2'b00, 0, 1, 1'b0, 2'b00};
        vecs[6] = '{"timeout",    48, 47, 0,      2'b00, 0, 1, 1'b1, 2'b11};
        vecs[7] = '{"normal_b",   48, 47, 7,      2'b10, 0, 1, 1'b0, 2'b10};

        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
        bus.s_last   = 1'b0;
        bus.nn_done  = 1'b0;
        bus.nn_class = 2'b00;
        bus.r_ready  = 1'b1;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        step(2);

        check("rst_s_ready", 64'(bus.s_ready), 1);
        check("rst_nn_valid", 64'(bus.nn_valid), 0);
        check("rst_r_valid", 64'(bus.r_valid), 0);
        check("rst_r_class", 64'(bus.r_class), 0);
        check("rst_r_timeout", 64'(bus.r_timeout), 0);
        check("rst_frame_err", 64'(bus.frame_err), 0);
        check("rst_frames_done", 64'(bus.frames_done), 0);
        check_bus("rst_pixel_bus", bus.pixel_bus, '0);

        rst_n = 1'b1;
        step(1);

        for (int i = 0; i < 8; i++) apply(vecs[i], i);

        // Backpressure: result held for 50 cycles with r_ready low.
        bus.r_ready = 1'b0;
        r.cls = 2'b10;
        r.to  = 1'b0;
        sb.push_back(r);
        send_frame("backpressure", NB, NB - 1, 9, 1);
        step(5);
        bus.nn_done  = 1'b1;
        bus.nn_class = 2'b10;
        step(1);
        bus.nn_done  = 1'b0;
        bus.nn_class = 2'b00;
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.r_valid !== 1'b1 || bus.r_class !== 2'b10 ||
                bus.r_timeout !== 1'b0 || bus.s_ready !== 1'b0) hold_bad++;
            step(1);
        end
        check("bp_hold_cycles_bad", 64'(hold_bad), 0);
        bus.r_ready = 1'b1;
        step(1);
        check("bp_s_ready_next", 64'(bus.s_ready), 1);
        check("bp_r_valid_drop", 64'(bus.r_valid), 0);
        check("bp_frames_done", 64'(bus.frames_done), 64'(exp_frames));
        check("bp_sb_drained", 64'(sb.size()), 0);

        // Reset while waiting for the classifier.
        send_frame("rst_wait", NB, NB - 1, 3, 1);
        step(4);
        rst_n = 1'b0;
        #1;
        check("rstw_s_ready", 64'(bus.s_ready), 1);
        check("rstw_r_valid", 64'(bus.r_valid), 0);
        check_bus("rstw_pixel_bus", bus.pixel_bus, '0);
        step(2);
        rst_n = 1'b1;
        step(1);
        bus.nn_done  = 1'b1;
        bus.nn_class = 2'b10;
        step(1);
        bus.nn_done  = 1'b0;
        bus.nn_class = 2'b00;
        step(2);
        check("rstw_no_result", 64'(bus.r_valid), 0);
        check("rstw_s_ready_after", 64'(bus.s_ready), 1);
        check("rstw_frames_done", 64'(bus.frames_done), 0);
        check_bus("rstw_pixel_after", bus.pixel_bus, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
